// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit: tracks pending register writes from EXE to WB,
// picks each EXE operand source at ID, and stalls ID when load data cannot arrive in time.
module fwd_hazard_unit #(
   parameter int  DATA_W     = 32,
   parameter int  ADDR_W     = 5,
   parameter int  NUM_RD     = 2,
   parameter int  DEPTH      = 3,
   parameter int  LOAD_STAGE = 2,
   localparam int SEL_W      = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       pipe_en,
   input  logic                       flush,
   input  logic                       id_valid,
   input  logic                       id_wen,
   input  logic [ADDR_W-1:0]          id_waddr,
   input  logic                       id_is_load,
   input  logic [NUM_RD*ADDR_W-1:0]   id_raddr,
   input  logic [NUM_RD-1:0]          id_rused,
   input  logic [NUM_RD*DATA_W-1:0]   id_rf_data,
   input  logic [DEPTH*DATA_W-1:0]    stage_data,
   output logic                       stall,
   output logic [NUM_RD*DATA_W-1:0]   exe_opnd,
   output logic [NUM_RD*SEL_W-1:0]    exe_fwd_sel,
   output logic [31:0]                stall_cnt
);

   logic [DEPTH-1:0]                vld_q, vld_d;
   logic [DEPTH-1:0]                wen_q, wen_d;
   logic [DEPTH-1:0]                load_q, load_d;
   logic [DEPTH-1:0][ADDR_W-1:0]    waddr_q, waddr_d;
   logic [NUM_RD-1:0][DATA_W-1:0]   opnd_q, opnd_d;
   logic [NUM_RD-1:0][SEL_W-1:0]    sel_q, sel_d;
   logic [31:0]                     stall_cnt_q, stall_cnt_d;

   logic [NUM_RD-1:0]               hit;
   logic [NUM_RD-1:0]               hazard;
   logic [NUM_RD-1:0][SEL_W-1:0]    hit_k;
   logic [NUM_RD-1:0][DATA_W-1:0]   exe_mux;
   logic                            unused_slot0;

   // Producer in slot 0 is still computing at EXE, so its result is never read here.
   assign unused_slot0 = ^stage_data[DATA_W-1:0];

   // Scan oldest to youngest so the youngest matching producer is the one kept.
   always_comb begin
      hit    = '0;
      hazard = '0;
      hit_k  = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (id_rused[p] && (id_raddr[p*ADDR_W +: ADDR_W] != '0) &&
                vld_q[k] && wen_q[k] &&
                (waddr_q[k] == id_raddr[p*ADDR_W +: ADDR_W])) begin
               hit[p]   = 1'b1;
               hit_k[p] = SEL_W'(k);
            end
         end
         hazard[p] = hit[p] && load_q[hit_k[p]] &&
                     ((int'(hit_k[p]) + 1) < LOAD_STAGE);
      end
   end

   assign stall = id_valid & (|hazard) & ~flush;

   always_comb begin
      vld_d[0]   = id_valid & ~stall & ~flush;
      wen_d[0]   = vld_d[0] & id_wen;
      waddr_d[0] = vld_d[0] ? id_waddr : '0;
      load_d[0]  = vld_d[0] & id_is_load;
      for (int j = 1; j < DEPTH; j++) begin
         vld_d[j]   = vld_q[j-1];
         wen_d[j]   = wen_q[j-1];
         waddr_d[j] = waddr_q[j-1];
         load_d[j]  = load_q[j-1];
      end

      // A WB-stage producer is gone by EXE, so its value is captured now instead of bypassed later.
      for (int p = 0; p < NUM_RD; p++) begin
         opnd_d[p] = id_rf_data[p*DATA_W +: DATA_W];
         sel_d[p]  = '0;
         if (stall) begin
            opnd_d[p] = '0;
         end else if (hit[p]) begin
            if (hit_k[p] == SEL_W'(DEPTH - 1)) begin
               opnd_d[p] = stage_data[(DEPTH-1)*DATA_W +: DATA_W];
            end else begin
               sel_d[p] = hit_k[p] + SEL_W'(1);
            end
         end
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q       <= '0;
         wen_q       <= '0;
         load_q      <= '0;
         waddr_q     <= '0;
         opnd_q      <= '0;
         sel_q       <= '0;
         stall_cnt_q <= '0;
      end else if (pipe_en) begin
         vld_q       <= vld_d;
         wen_q       <= wen_d;
         load_q      <= load_d;
         waddr_q     <= waddr_d;
         opnd_q      <= opnd_d;
         sel_q       <= sel_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         exe_mux[p] = opnd_q[p];
         for (int j = 1; j < DEPTH; j++) begin
            if (sel_q[p] == SEL_W'(j)) begin
               exe_mux[p] = stage_data[j*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign exe_opnd    = exe_mux;
   assign exe_fwd_sel = sel_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit at default parameters: table of per-cycle vectors
// with a scoreboard queue for EXE results, followed by hand-written multi-cycle sequences.
module tb_fwd_hazard_unit;

   logic        clk;
   logic        rst_n;
   logic        pipe_en;
   logic        flush;
   logic        id_valid;
   logic        id_wen;
   logic [4:0]  id_waddr;
   logic        id_is_load;
   logic [9:0]  id_raddr;
   logic [1:0]  id_rused;
   logic [63:0] id_rf_data;
   logic [95:0] stage_data;
   logic        stall;
   logic [63:0] exe_opnd;
   logic [3:0]  exe_fwd_sel;
   logic [31:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        vld, wen;
      logic [4:0]  wa;
      logic        ld;
      logic [4:0]  ra0, ra1;
      logic [1:0]  used;
      logic [31:0] rf0, rf1, sd1, sd2;
      logic        flush, pe;
      logic        estall;
      logic [1:0]  es0, es1;
      logic [31:0] eo0, eo1;
   } vec_t;

   typedef struct {
      logic [1:0]  s0, s1;
      logic [31:0] o0, o1;
   } exp_t;

   localparam int NVEC = 19;
   vec_t tbl [NVEC];
   exp_t sbq [$];

   fwd_hazard_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pipe_en     (pipe_en),
      .flush       (flush),
      .id_valid    (id_valid),
      .id_wen      (id_wen),
      .id_waddr    (id_waddr),
      .id_is_load  (id_is_load),
      .id_raddr    (id_raddr),
      .id_rused    (id_rused),
      .id_rf_data  (id_rf_data),
      .stage_data  (stage_data),
      .stall       (stall),
      .exe_opnd    (exe_opnd),
      .exe_fwd_sel (exe_fwd_sel),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic vld, input logic wen, input logic [4:0] wa,
                               input logic ld, input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic [1:0] used, input logic [31:0] rf0,
                               input logic [31:0] rf1, input logic [31:0] sd1,
                               input logic [31:0] sd2, input logic estall,
                               input logic [1:0] es0, input logic [1:0] es1,
                               input logic [31:0] eo0, input logic [31:0] eo1);
      vec_t v;
      v.vld = vld;  v.wen = wen;  v.wa = wa;  v.ld = ld;
      v.ra0 = ra0;  v.ra1 = ra1;  v.used = used;
      v.rf0 = rf0;  v.rf1 = rf1;  v.sd1 = sd1;  v.sd2 = sd2;
      v.flush = 1'b0;  v.pe = 1'b1;
      v.estall = estall;  v.es0 = es0;  v.es1 = es1;  v.eo0 = eo0;  v.eo1 = eo1;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      pipe_en    = v.pe;
      flush      = v.flush;
      id_valid   = v.vld;
      id_wen     = v.wen;
      id_waddr   = v.wa;
      id_is_load = v.ld;
      id_raddr   = {v.ra1, v.ra0};
      id_rused   = v.used;
      id_rf_data = {v.rf1, v.rf0};
      stage_data = {v.sd2, v.sd1, 32'h0};
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      exp_t e;

      //        vld wen wa  ld ra0 ra1 used   rf0      rf1      sd1     sd2      st s0 s1 eo0      eo1
      tbl[0]  = mk(1, 1, 3,  0, 1,  2,  2'b11, 'h100,   'h200,   0,      0,       0, 0, 0, 'h100,   'h200);
      tbl[1]  = mk(1, 1, 4,  0, 3,  3,  2'b11, 'h999,   'h999,   'h11,   0,       0, 1, 1, 'h11,    'h11);
      tbl[2]  = mk(1, 1, 5,  1, 1,  0,  2'b01, 5,       6,       0,      0,       0, 0, 0, 5,       6);
      tbl[3]  = mk(1, 1, 6,  0, 5,  0,  2'b11, 'h77,    'h88,    0,      0,       1, 0, 0, 0,       0);
      tbl[4]  = mk(1, 1, 6,  0, 5,  0,  2'b11, 'h77,    'h88,    0,      'hDEAD,  0, 2, 0, 'hDEAD,  'h88);
      tbl[5]  = mk(1, 1, 7,  0, 0,  0,  2'b00, 1,       2,       0,      0,       0, 0, 0, 1,       2);
      tbl[6]  = mk(1, 1, 7,  0, 0,  0,  2'b00, 3,       4,       0,      0,       0, 0, 0, 3,       4);
      tbl[7]  = mk(1, 0, 0,  0, 7,  7,  2'b11, 'h55,    'h66,    'hBB,   'hAA,    0, 1, 1, 'hBB,    'hBB);
      tbl[8]  = mk(1, 1, 9,  0, 0,  0,  2'b00, 'h10,    'h20,    0,      0,       0, 0, 0, 'h10,    'h20);
      tbl[9]  = mk(0, 0, 0,  0, 0,  0,  2'b00, 'h30,    'h40,    0,      0,       0, 0, 0, 'h30,    'h40);
      tbl[10] = mk(0, 0, 0,  0, 0,  0,  2'b00, 5,       6,       0,      0,       0, 0, 0, 5,       6);
      tbl[11] = mk(1, 0, 0,  0, 9,  9,  2'b01, 0,       'h66,    0,      'h1234,  0, 0, 0, 'h1234,  'h66);
      tbl[12] = mk(1, 1, 0,  0, 0,  0,  2'b00, 1,       1,       0,      0,       0, 0, 0, 1,       1);
      tbl[13] = mk(1, 0, 0,  0, 0,  0,  2'b11, 'hA0,    'hB0,    'hFF,   0,       0, 0, 0, 'hA0,    'hB0);
      tbl[14] = mk(1, 1, 8,  1, 0,  0,  2'b00, 2,       3,       0,      0,       0, 0, 0, 2,       3);
      tbl[15] = mk(1, 0, 0,  0, 8,  8,  2'b00, 'hC0,    'hD0,    'h99,   0,       0, 0, 0, 'hC0,    'hD0);
      tbl[16] = mk(1, 1, 10, 1, 0,  0,  2'b00, 7,       8,       0,      0,       0, 0, 0, 7,       8);
      tbl[17] = mk(1, 0, 0,  0, 1,  10, 2'b10, 1,       2,       0,      0,       1, 0, 0, 0,       0);
      tbl[18] = mk(1, 0, 0,  0, 1,  10, 2'b10, 1,       2,       0,      'hBEEF,  0, 0, 2, 1,       'hBEEF);

      rst_n = 1'b0;
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 2'b00, 'h1, 'h2, 'h3, 'h4, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset stall", 32'(stall), 32'h0);
      checkOutput("reset opnd0", exe_opnd[31:0], 32'h0);
      checkOutput("reset opnd1", exe_opnd[63:32], 32'h0);
      checkOutput("reset sel", 32'(exe_fwd_sel), 32'h0);
      checkOutput("reset cnt", stall_cnt, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(tbl[i]);
         sbq.push_back('{s0: tbl[i].es0, s1: tbl[i].es1, o0: tbl[i].eo0, o1: tbl[i].eo1});
         @(negedge clk);
         checkOutput($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].estall));
         tick();
         e = sbq.pop_front();
         checkOutput($sformatf("v%0d sel0", i), 32'(exe_fwd_sel[1:0]), 32'(e.s0));
         checkOutput($sformatf("v%0d sel1", i), 32'(exe_fwd_sel[3:2]), 32'(e.s1));
         checkOutput($sformatf("v%0d opnd0", i), exe_opnd[31:0], e.o0);
         checkOutput($sformatf("v%0d opnd1", i), exe_opnd[63:32], e.o1);
      end
      checkOutput("table stall_cnt", stall_cnt, 32'd2);

      // Freeze the pipe while a load-use hazard is pending.
      applyStimulus(mk(1, 1, 11, 1, 0, 0, 2'b00, 'h4242, 'h4343, 0, 0, 0, 0, 0, 0, 0));
      tick();
      v = mk(1, 1, 14, 0, 11, 0, 2'b01, 1, 2, 0, 0, 0, 0, 0, 0, 0);
      v.pe = 1'b0;
      applyStimulus(v);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("frz%0d stall", c), 32'(stall), 32'h1);
         tick();
         checkOutput($sformatf("frz%0d cnt", c), stall_cnt, 32'd2);
         checkOutput($sformatf("frz%0d opnd0", c), exe_opnd[31:0], 32'h4242);
      end
      v.pe  = 1'b1;
      v.sd2 = 32'hCAFE;
      applyStimulus(v);
      @(negedge clk);
      checkOutput("unfrz stall", 32'(stall), 32'h1);
      tick();
      checkOutput("unfrz cnt", stall_cnt, 32'd3);
      checkOutput("unfrz bubble opnd0", exe_opnd[31:0], 32'h0);
      @(negedge clk);
      checkOutput("retry stall", 32'(stall), 32'h0);
      tick();
      checkOutput("retry sel0", 32'(exe_fwd_sel[1:0]), 32'h2);
      checkOutput("retry opnd0", exe_opnd[31:0], 32'hCAFE);

      // Flush wins over a simultaneous stall.
      applyStimulus(mk(1, 1, 12, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      v = mk(1, 0, 0, 0, 12, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.flush = 1'b1;
      applyStimulus(v);
      @(negedge clk);
      checkOutput("flush stall", 32'(stall), 32'h0);
      tick();
      checkOutput("flush cnt", stall_cnt, 32'd3);
      v.flush = 1'b0;
      applyStimulus(v);
      @(negedge clk);
      checkOutput("post-flush stall", 32'(stall), 32'h0);
      tick();

      // WB-stage capture must hold after stage_data moves on.
      applyStimulus(mk(1, 1, 9, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      tick();
      applyStimulus(mk(1, 0, 0, 0, 9, 0, 2'b01, 0, 0, 0, 'h1234, 0, 0, 0, 0, 0));
      tick();
      checkOutput("wb sel0", 32'(exe_fwd_sel[1:0]), 32'h0);
      checkOutput("wb opnd0", exe_opnd[31:0], 32'h1234);
      stage_data = {32'h5555, 32'h7777, 32'h0};
      #1;
      checkOutput("wb hold opnd0", exe_opnd[31:0], 32'h1234);

      // Asynchronous reset in the middle of a hazard.
      applyStimulus(mk(1, 1, 13, 1, 0, 0, 2'b00, 'h31, 'h32, 0, 0, 0, 0, 0, 0, 0));
      tick();
      applyStimulus(mk(1, 0, 0, 0, 13, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      checkOutput("pre-rst stall", 32'(stall), 32'h1);
      checkOutput("pre-rst opnd0", exe_opnd[31:0], 32'h31);
      rst_n = 1'b0;
      #1;
      checkOutput("rst stall", 32'(stall), 32'h0);
      checkOutput("rst opnd0", exe_opnd[31:0], 32'h0);
      checkOutput("rst opnd1", exe_opnd[63:32], 32'h0);
      checkOutput("rst sel", 32'(exe_fwd_sel), 32'h0);
      checkOutput("rst cnt", stall_cnt, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
